// File: rtl/twiddle_cmul_stage_if.sv
// Streaming bundle for the twiddle complex multiplier: operand side (x, w) and result side (y).
// master = upstream/downstream environment, slave = the multiplier stage.
interface twiddle_cmul_stage_if #(
  parameter int DW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x_re;
  logic signed [DW-1:0] x_im;
  logic signed [DW-1:0] w_re;
  logic signed [DW-1:0] w_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] y_re;
  logic signed [DW-1:0] y_im;

  modport master (
    output in_valid, x_re, x_im, w_re, w_im, out_ready,
    input  in_ready, out_valid, y_re, y_im
  );

  modport slave (
    input  in_valid, x_re, x_im, w_re, w_im, out_ready,
    output in_ready, out_valid, y_re, y_im
  );
endinterface

// File: rtl/twiddle_cmul_stage.sv
// Three-stage pipelined complex multiply y = x * w in Q1.(DW-1) with rounding and sticky overflow flag.
// Define CMUL_SATURATE_EN to clamp out-of-range results; otherwise they wrap to the low DW bits.
module twiddle_cmul_stage #(
  parameter int DW   = 16,
  parameter int FRAC = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  twiddle_cmul_stage_if.slave    bus,
  input  logic                   ovf_clr,
  output logic                   ovf_flag
);

  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + 1;
  localparam int RW = SW + 1;

  localparam logic signed [RW-1:0] HALF = {{(RW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [RW-1:0] MAXV = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] YMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] YMIN = {1'b1, {(DW-1){1'b0}}};

  logic                 adv;
  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [PW-1:0] p_ac_q, p_ac_d, p_bd_q, p_bd_d;
  logic signed [PW-1:0] p_ad_q, p_ad_d, p_bc_q, p_bc_d;
  logic signed [SW-1:0] s_re_q, s_re_d, s_im_q, s_im_d;
  logic signed [DW-1:0] y_re_q, y_re_d, y_im_q, y_im_d;
  logic                 ovf_q, ovf_d;

  logic signed [RW-1:0] r_re, r_im;
  logic                 oor_re, oor_im;
  logic signed [DW-1:0] f_re, f_im;

  // One global enable: the whole pipe freezes while a result waits at the output.
  assign adv          = !v3_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v3_q;
  assign bus.y_re     = y_re_q;
  assign bus.y_im     = y_im_q;
  assign ovf_flag     = ovf_q;

  always_comb begin
    r_re   = (RW'(s_re_q) + HALF) >>> FRAC;
    r_im   = (RW'(s_im_q) + HALF) >>> FRAC;
    oor_re = (r_re > MAXV) || (r_re < MINV);
    oor_im = (r_im > MAXV) || (r_im < MINV);
`ifdef CMUL_SATURATE_EN
    f_re = oor_re ? ((r_re < MINV) ? YMIN : YMAX) : r_re[DW-1:0];
    f_im = oor_im ? ((r_im < MINV) ? YMIN : YMAX) : r_im[DW-1:0];
`else
    f_re = r_re[DW-1:0];
    f_im = r_im[DW-1:0];
`endif
  end

  always_comb begin
    v1_d   = v1_q;
    p_ac_d = p_ac_q;
    p_bd_d = p_bd_q;
    p_ad_d = p_ad_q;
    p_bc_d = p_bc_q;
    v2_d   = v2_q;
    s_re_d = s_re_q;
    s_im_d = s_im_q;
    v3_d   = v3_q;
    y_re_d = y_re_q;
    y_im_d = y_im_q;
    if (adv) begin
      v1_d   = bus.in_valid;
      p_ac_d = PW'(bus.x_re) * PW'(bus.w_re);
      p_bd_d = PW'(bus.x_im) * PW'(bus.w_im);
      p_ad_d = PW'(bus.x_re) * PW'(bus.w_im);
      p_bc_d = PW'(bus.x_im) * PW'(bus.w_re);
      v2_d   = v1_q;
      s_re_d = SW'(p_ac_q) - SW'(p_bd_q);
      s_im_d = SW'(p_ad_q) + SW'(p_bc_q);
      v3_d   = v2_q;
      y_re_d = f_re;
      y_im_d = f_im;
    end
  end

  // Overflow set wins over a coincident clear so no event is ever lost.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (adv && v2_q && (oor_re || oor_im)) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      p_ac_q <= '0;
      p_bd_q <= '0;
      p_ad_q <= '0;
      p_bc_q <= '0;
      s_re_q <= '0;
      s_im_q <= '0;
      y_re_q <= '0;
      y_im_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      p_ac_q <= p_ac_d;
      p_bd_q <= p_bd_d;
      p_ad_q <= p_ad_d;
      p_bc_q <= p_bc_d;
      s_re_q <= s_re_d;
      s_im_q <= s_im_d;
      y_re_q <= y_re_d;
      y_im_q <= y_im_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_twiddle_cmul_stage.sv
// Self-checking bench for twiddle_cmul_stage: arithmetic reference model plus scoreboard, directed corners
// and randomized streams with back-pressure.
module tb_twiddle_cmul_stage;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    bit                 ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic ovf_clr;
  logic ovf_flag;
  int   checks = 0;
  int   failures = 0;
  res_t sb[$];
  bit   hold_prev = 1'b0;
  logic signed [15:0] hold_re, hold_im;
  bit   feed_done;

  twiddle_cmul_stage_if #(.DW(16)) bus ();

  twiddle_cmul_stage #(.DW(16), .FRAC(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ovf_clr  (ovf_clr),
    .ovf_flag (ovf_flag)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] fit(input longint r);
    logic [63:0] u;
`ifdef CMUL_SATURATE_EN
    if (r > 32767) return 16'sd32767;
    if (r < -32768) return -16'sd32768;
`endif
    u = r;
    return u[15:0];
  endfunction

  // Exact complex product, round half up, scale by 2^-15.
  function automatic res_t model(input int xr, input int xi, input int wr, input int wi);
    res_t   o;
    longint sre, sim, rre, rim;
    sre   = longint'(xr) * wr - longint'(xi) * wi;
    sim   = longint'(xr) * wi + longint'(xi) * wr;
    rre   = (sre + 16384) >>> 15;
    rim   = (sim + 16384) >>> 15;
    o.ovf = (rre > 32767) || (rre < -32768) || (rim > 32767) || (rim < -32768);
    o.re  = fit(rre);
    o.im  = fit(rim);
    return o;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int xr, input int xi, input int wr, input int wi);
    int n = 0;
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.x_re = 16'(xr);
    bus.x_im = 16'(xi);
    bus.w_re = 16'(wr);
    bus.w_im = 16'(wi);
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) checkOutput("input_accept_timeout", 0, 1);
  endtask

  task automatic waitDrain();
    int n = 0;
    bus.out_ready = 1'b1;
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_timeout", longint'(n < 200), 1);
  endtask

  function automatic int rnd16();
    logic [15:0] u;
    case ($urandom_range(0, 7))
      0: return -32768;
      1: return 32767;
      default: begin
        u = 16'($urandom);
        return int'($signed(u));
      end
    endcase
  endfunction

  // Scoreboard: compare every output transfer, check stall stability, capture accepted inputs.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      sb.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checkOutput("hold_valid", longint'(bus.out_valid), 1);
        checkOutput("hold_y_re", bus.y_re, hold_re);
        checkOutput("hold_y_im", bus.y_im, hold_im);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("y_re", bus.y_re, e.re);
          checkOutput("y_im", bus.y_im, e.im);
          if (e.ovf) checkOutput("ovf_on_item", longint'(ovf_flag), 1);
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      hold_re   = bus.y_re;
      hold_im   = bus.y_im;
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(bus.x_re, bus.x_im, bus.w_re, bus.w_im));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    res_t m;
    rst = 1'b1;
    ovf_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.x_re = '0;
    bus.x_im = '0;
    bus.w_re = '0;
    bus.w_im = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", longint'(bus.out_valid), 0);
    checkOutput("reset_y_re", bus.y_re, 0);
    checkOutput("reset_y_im", bus.y_im, 0);
    checkOutput("reset_ovf", longint'(ovf_flag), 0);
    rst = 1'b0;

    // Hand-computed pins for the reference model.
    m = model(16384, 0, 16384, 16384);
    checkOutput("model_pin1_re", m.re, 8192);
    checkOutput("model_pin1_im", m.im, 8192);
    m = model(1, 0, 16384, 0);
    checkOutput("model_pin2_re", m.re, 1);
    m = model(-1, 0, 16384, 0);
    checkOutput("model_pin3_re", m.re, 0);
    m = model(-32768, 0, -32768, 0);
    checkOutput("model_pin4_ovf", longint'(m.ovf), 1);
`ifdef CMUL_SATURATE_EN
    checkOutput("model_pin4_re", m.re, 32767);
`else
    checkOutput("model_pin4_re", m.re, -32768);
`endif

    @(posedge clk);
    #1;
    applyStimulus(16384, 0, 16384, 16384);
    checkOutput("lat_cycle1_valid", longint'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    checkOutput("lat_cycle2_valid", longint'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    checkOutput("lat_cycle3_valid", longint'(bus.out_valid), 1);
    checkOutput("t1_y_re", bus.y_re, 8192);
    checkOutput("t1_y_im", bus.y_im, 8192);
    checkOutput("t1_ovf", longint'(ovf_flag), 0);
    waitDrain();

    applyStimulus(1, 0, 16384, 0);
    applyStimulus(-1, 0, 16384, 0);
    waitDrain();
    checkOutput("t2_ovf", longint'(ovf_flag), 0);

    applyStimulus(-32768, 0, -32768, 0);
    waitDrain();
    checkOutput("t3_ovf_set", longint'(ovf_flag), 1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    checkOutput("t3_ovf_cleared", longint'(ovf_flag), 0);

    // Clear held across the cycle the overflowing result lands: set must win.
    applyStimulus(-32768, 0, -32768, 0);
    @(posedge clk);
    #1;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    checkOutput("t3_set_beats_clr", longint'(ovf_flag), 1);
    waitDrain();
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;

    feed_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(rnd16(), rnd16(), rnd16(), rnd16());
        feed_done = 1'b1;
      end
      begin
        for (int n = 0; n < 400 && !feed_done; n++) begin
          @(posedge clk);
          #1;
          bus.out_ready = ~bus.out_ready;
        end
      end
    join
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      bus.out_ready = ~bus.out_ready;
    end
    waitDrain();

    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    applyStimulus(32767, -32768, 32767, 32767);
    waitDrain();
    checkOutput("t6_ovf", longint'(ovf_flag), 1);

    feed_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          applyStimulus(rnd16(), rnd16(), rnd16(), rnd16());
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        feed_done = 1'b1;
      end
      begin
        for (int n = 0; n < 2000 && !feed_done; n++) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    waitDrain();

    // Reset with three items in flight: nothing may surface afterwards.
    applyStimulus(100, 200, 300, 400);
    applyStimulus(-500, 600, 700, -800);
    applyStimulus(900, -1000, 1100, 1200);
    rst = 1'b1;
    #1;
    checkOutput("t5_out_valid", longint'(bus.out_valid), 0);
    checkOutput("t5_y_re", bus.y_re, 0);
    checkOutput("t5_y_im", bus.y_im, 0);
    checkOutput("t5_ovf", longint'(ovf_flag), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checkOutput("t5_no_output", longint'(bus.out_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
